// File: rtl/regfile_writeback_queue.sv
// In-order writeback queue feeding the single register file write port.
// Optional bypass of pending write data to the decode read ports: define WBQ_BYPASS_EN.
module regfile_writeback_queue #(
  parameter int dataW = 32,
  parameter int addrW = 5,
  parameter int DEPTH = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         WbValid,
  output logic                         WbReady,
  input  logic [addrW-1:0]             WbAddr,
  input  logic [dataW-1:0]             WbData,
  input  logic                         RegPortBusy,
  output logic                         RegWriteControl,
  output logic [addrW-1:0]             RegWriteAddr,
  output logic [dataW-1:0]             RegDataIn,
  input  logic [addrW-1:0]             RdAddr1,
  input  logic [addrW-1:0]             RdAddr2,
  output logic                         BypassHit1,
  output logic                         BypassHit2,
  output logic [dataW-1:0]             BypassData1,
  output logic [dataW-1:0]             BypassData2,
  output logic [$clog2(DEPTH+1)-1:0]   Count,
  output logic                         Empty
);

  localparam int PtrW = $clog2(DEPTH);
  localparam int CntW = $clog2(DEPTH+1);

  logic [addrW-1:0] entryAddr_q [DEPTH];
  logic [dataW-1:0] entryData_q [DEPTH];
  logic [DEPTH-1:0] entryValid_q;
  logic [PtrW-1:0]  wrPtr_q, wrPtr_d;
  logic [PtrW-1:0]  rdPtr_q, rdPtr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             push;
  logic             pop;

  assign Count   = count_q;
  assign Empty   = (count_q == '0);
  assign WbReady = (count_q < CntW'(DEPTH));

  // Writes to x0 complete the handshake but are dropped here.
  assign push = WbValid && WbReady && (WbAddr != '0);
  assign pop  = RegWriteControl;

  assign RegWriteControl = !Empty && !RegPortBusy && !reset;
  assign RegWriteAddr    = Empty ? '0 : entryAddr_q[rdPtr_q];
  assign RegDataIn       = Empty ? '0 : entryData_q[rdPtr_q];

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (push) begin
      wrPtr_d = wrPtr_q + 1'b1;
    end
    if (pop) begin
      rdPtr_d = rdPtr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wrPtr_q      <= '0;
      rdPtr_q      <= '0;
      count_q      <= '0;
      entryValid_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
      // Push and pop never hit the same slot: that would need a full queue accepting.
      if (push) begin
        entryValid_q[wrPtr_q] <= 1'b1;
      end
      if (pop) begin
        entryValid_q[rdPtr_q] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      entryAddr_q[wrPtr_q] <= WbAddr;
      entryData_q[wrPtr_q] <= WbData;
    end
  end

`ifdef WBQ_BYPASS_EN
  logic [PtrW-1:0] scanIdx;

  // Scan oldest to youngest so the last match wins.
  always_comb begin
    BypassHit1  = 1'b0;
    BypassHit2  = 1'b0;
    BypassData1 = '0;
    BypassData2 = '0;
    scanIdx     = '0;
    for (int k = 0; k < DEPTH; k++) begin
      scanIdx = rdPtr_q + PtrW'(k);
      if (entryValid_q[scanIdx] && (RdAddr1 != '0) && (entryAddr_q[scanIdx] == RdAddr1)) begin
        BypassHit1  = 1'b1;
        BypassData1 = entryData_q[scanIdx];
      end
      if (entryValid_q[scanIdx] && (RdAddr2 != '0) && (entryAddr_q[scanIdx] == RdAddr2)) begin
        BypassHit2  = 1'b1;
        BypassData2 = entryData_q[scanIdx];
      end
    end
  end
`else
  logic unusedBypassInputs;

  assign BypassHit1         = 1'b0;
  assign BypassHit2         = 1'b0;
  assign BypassData1        = '0;
  assign BypassData2        = '0;
  assign unusedBypassInputs = ^{RdAddr1, RdAddr2, entryValid_q};
`endif

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Self-checking bench for regfile_writeback_queue; follows WBQ_BYPASS_EN for bypass expectations.
module tb_regfile_writeback_queue;

  localparam int dataW = 32;
  localparam int addrW = 5;
  localparam int DEPTH = 4;
  localparam int CntW  = $clog2(DEPTH+1);

  logic             clock;
  logic             reset;
  logic             WbValid;
  logic             WbReady;
  logic [addrW-1:0] WbAddr;
  logic [dataW-1:0] WbData;
  logic             RegPortBusy;
  logic             RegWriteControl;
  logic [addrW-1:0] RegWriteAddr;
  logic [dataW-1:0] RegDataIn;
  logic [addrW-1:0] RdAddr1;
  logic [addrW-1:0] RdAddr2;
  logic             BypassHit1;
  logic             BypassHit2;
  logic [dataW-1:0] BypassData1;
  logic [dataW-1:0] BypassData2;
  logic [CntW-1:0]  Count;
  logic             Empty;

  regfile_writeback_queue #(.dataW(dataW), .addrW(addrW), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .WbValid(WbValid), .WbReady(WbReady), .WbAddr(WbAddr), .WbData(WbData),
    .RegPortBusy(RegPortBusy), .RegWriteControl(RegWriteControl),
    .RegWriteAddr(RegWriteAddr), .RegDataIn(RegDataIn),
    .RdAddr1(RdAddr1), .RdAddr2(RdAddr2),
    .BypassHit1(BypassHit1), .BypassHit2(BypassHit2),
    .BypassData1(BypassData1), .BypassData2(BypassData2),
    .Count(Count), .Empty(Empty)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

`ifdef WBQ_BYPASS_EN
  localparam bit bypassBuilt = 1'b1;
`else
  localparam bit bypassBuilt = 1'b0;
`endif

  typedef struct packed {
    logic [addrW-1:0] addr;
    logic [dataW-1:0] data;
  } entry_t;

  typedef struct {
    logic [addrW-1:0] addr;
    logic [dataW-1:0] data;
    int               cyc;
  } write_t;

  int         testsRun = 0;
  int         testsFailed = 0;
  int         cycle = 0;
  bit         modelLive = 1'b0;
  entry_t     modelQ[$];
  write_t     writeLog[$];
  logic [dataW-1:0] tbRf [32];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void modelBypass(input logic [addrW-1:0] ra, output logic hit, output logic [dataW-1:0] d);
    hit = 1'b0;
    d   = '0;
    if (bypassBuilt && ra != '0) begin
      foreach (modelQ[i]) begin
        if (modelQ[i].addr == ra) begin
          hit = 1'b1;
          d   = modelQ[i].data;
        end
      end
    end
  endfunction

  // Queue model: advances on each edge from the inputs presented during the cycle.
  bit modelPop;
  bit modelPush;
  always @(posedge clock) begin
    cycle++;
    if (reset) begin
      modelQ.delete();
    end else begin
      modelPop  = (modelQ.size() > 0) && !RegPortBusy;
      modelPush = WbValid && (modelQ.size() < DEPTH);
      if (modelPop) void'(modelQ.pop_front());
      if (modelPush && WbAddr != '0) modelQ.push_back('{WbAddr, WbData});
    end
    modelLive = 1'b1;
  end

  // Mid-cycle compare against the model; also acts as the register file.
  logic             expHit1, expHit2;
  logic [dataW-1:0] expData1, expData2;
  always @(negedge clock) begin
    if (modelLive) begin
      modelBypass(RdAddr1, expHit1, expData1);
      modelBypass(RdAddr2, expHit2, expData2);
      checkOutput("cmp_ready", {31'b0, WbReady}, {31'b0, modelQ.size() < DEPTH});
      checkOutput("cmp_count", 32'(Count), 32'(modelQ.size()));
      checkOutput("cmp_empty", {31'b0, Empty}, {31'b0, modelQ.size() == 0});
      checkOutput("cmp_wen", {31'b0, RegWriteControl},
                  {31'b0, (modelQ.size() > 0) && !RegPortBusy && !reset});
      checkOutput("cmp_waddr", 32'(RegWriteAddr), (modelQ.size() > 0) ? 32'(modelQ[0].addr) : 32'd0);
      checkOutput("cmp_wdata", RegDataIn, (modelQ.size() > 0) ? modelQ[0].data : 32'd0);
      checkOutput("cmp_hit1", {31'b0, BypassHit1}, {31'b0, expHit1});
      checkOutput("cmp_hit2", {31'b0, BypassHit2}, {31'b0, expHit2});
      checkOutput("cmp_bdata1", BypassData1, expData1);
      checkOutput("cmp_bdata2", BypassData2, expData2);
      if (RegWriteControl === 1'b1) begin
        writeLog.push_back('{RegWriteAddr, RegDataIn, cycle});
        tbRf[RegWriteAddr] = RegDataIn;
      end
    end
  end

  task automatic applyStimulus(input logic v, input logic [addrW-1:0] a, input logic [dataW-1:0] d, input logic busy);
    WbValid     = v;
    WbAddr      = a;
    WbData      = d;
    RegPortBusy = busy;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Source holds the request until the queue accepts it.
  task automatic pushHeld(input logic [addrW-1:0] a, input logic [dataW-1:0] d);
    int guard;
    guard = 0;
    applyStimulus(1'b1, a, d, RegPortBusy);
    while (!WbReady && guard < 20) begin
      tick(1);
      guard++;
    end
    checkOutput("push_accept_bound", {31'b0, WbReady}, 32'd1);
    tick(1);
  endtask

  logic [addrW-1:0] s4Addr [9];
  logic [dataW-1:0] s4Data [9];
  int               startLen;
  int               guard;

  initial begin
    reset = 1'b1;
    RdAddr1 = '0;
    RdAddr2 = '0;
    foreach (tbRf[i]) tbRf[i] = '0;
    applyStimulus(1'b0, '0, '0, 1'b0);
    tick(2);
    reset = 1'b0;

    checkOutput("rst_ready", {31'b0, WbReady}, 32'd1);
    checkOutput("rst_wen", {31'b0, RegWriteControl}, 32'd0);
    checkOutput("rst_waddr", 32'(RegWriteAddr), 32'd0);
    checkOutput("rst_wdata", RegDataIn, 32'd0);
    checkOutput("rst_hit1", {31'b0, BypassHit1}, 32'd0);
    checkOutput("rst_bdata1", BypassData1, 32'd0);
    checkOutput("rst_count", 32'(Count), 32'd0);
    checkOutput("rst_empty", {31'b0, Empty}, 32'd1);

    // Single write appears on the port the cycle after acceptance.
    applyStimulus(1'b1, 5'd1, 32'd897, 1'b0);
    tick(1);
    applyStimulus(1'b0, '0, '0, 1'b0);
    checkOutput("s1_wen", {31'b0, RegWriteControl}, 32'd1);
    checkOutput("s1_waddr", 32'(RegWriteAddr), 32'd1);
    checkOutput("s1_wdata", RegDataIn, 32'd897);
    tick(1);
    checkOutput("s1_count", 32'(Count), 32'd0);
    checkOutput("s1_rf", tbRf[1], 32'd897);

    // Two pending writes to x2; bypass sees the younger one.
    writeLog.delete();
    RdAddr1 = 5'd2;
    applyStimulus(1'b1, 5'd2, 32'd666, 1'b1);
    tick(1);
    applyStimulus(1'b1, 5'd2, 32'd777, 1'b1);
    tick(1);
    applyStimulus(1'b0, '0, '0, 1'b1);
    checkOutput("s2_count", 32'(Count), 32'd2);
    checkOutput("s2_hit1", {31'b0, BypassHit1}, {31'b0, bypassBuilt});
    checkOutput("s2_bdata1", BypassData1, bypassBuilt ? 32'd777 : 32'd0);
    checkOutput("s2_hold_waddr", 32'(RegWriteAddr), 32'd2);
    checkOutput("s2_hold_wdata", RegDataIn, 32'd666);
    tick(1);
    applyStimulus(1'b0, '0, '0, 1'b0);
    tick(3);
    checkOutput("s2_nwrites", 32'(writeLog.size()), 32'd2);
    if (writeLog.size() >= 2) begin
      checkOutput("s2_w0_data", writeLog[0].data, 32'd666);
      checkOutput("s2_w1_data", writeLog[1].data, 32'd777);
      checkOutput("s2_w1_addr", 32'(writeLog[1].addr), 32'd2);
      checkOutput("s2_consecutive", 32'(writeLog[1].cyc - writeLog[0].cyc), 32'd1);
    end
    checkOutput("s2_rf", tbRf[2], 32'd777);

    // x0 writes are accepted but never stored or written.
    RdAddr1 = 5'd0;
    startLen = writeLog.size();
    applyStimulus(1'b1, 5'd0, 32'd123, 1'b0);
    checkOutput("s3_ready", {31'b0, WbReady}, 32'd1);
    tick(1);
    applyStimulus(1'b0, '0, '0, 1'b0);
    checkOutput("s3_count", 32'(Count), 32'd0);
    checkOutput("s3_empty", {31'b0, Empty}, 32'd1);
    checkOutput("s3_hit1", {31'b0, BypassHit1}, 32'd0);
    tick(2);
    checkOutput("s3_nowrite", 32'(writeLog.size()), 32'(startLen));

    // Fill while busy, hold the 5th, then drain with wrap-around.
    writeLog.delete();
    RdAddr2 = 5'd5;
    for (int i = 0; i < 9; i++) begin
      s4Addr[i] = addrW'(3 + i);
      s4Data[i] = 32'd1000 + 32'(i * 7);
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, s4Addr[i], s4Data[i], 1'b1);
      tick(1);
    end
    applyStimulus(1'b1, s4Addr[4], s4Data[4], 1'b1);
    checkOutput("s4_full_ready", {31'b0, WbReady}, 32'd0);
    checkOutput("s4_full_count", 32'(Count), 32'd4);
    checkOutput("s4_bdata2", BypassData2, bypassBuilt ? s4Data[2] : 32'd0);
    tick(2);
    checkOutput("s4_held_count", 32'(Count), 32'd4);
    RegPortBusy = 1'b0;
    for (int i = 4; i < 9; i++) begin
      pushHeld(s4Addr[i], s4Data[i]);
    end
    applyStimulus(1'b0, '0, '0, 1'b0);
    guard = 0;
    while (!Empty && guard < 30) begin
      tick(1);
      guard++;
    end
    checkOutput("s4_drain_bound", {31'b0, Empty}, 32'd1);
    checkOutput("s4_nwrites", 32'(writeLog.size()), 32'd9);
    for (int i = 0; i < 9 && i < writeLog.size(); i++) begin
      checkOutput($sformatf("s4_w%0d_addr", i), 32'(writeLog[i].addr), 32'(s4Addr[i]));
      checkOutput($sformatf("s4_w%0d_data", i), writeLog[i].data, s4Data[i]);
    end
    checkOutput("s4_rf_first", tbRf[3], 32'd1000);

    // Reset with entries pending discards them unwritten.
    writeLog.delete();
    RdAddr2 = 5'd0;
    applyStimulus(1'b1, 5'd20, 32'hAAAA_0001, 1'b1);
    tick(1);
    applyStimulus(1'b1, 5'd21, 32'hAAAA_0002, 1'b1);
    tick(1);
    applyStimulus(1'b1, 5'd22, 32'hAAAA_0003, 1'b1);
    tick(1);
    applyStimulus(1'b0, '0, '0, 1'b0);
    reset = 1'b1;
    checkOutput("s5_rst_wen", {31'b0, RegWriteControl}, 32'd0);
    checkOutput("s5_pre_count", 32'(Count), 32'd3);
    tick(1);
    reset = 1'b0;
    checkOutput("s5_count", 32'(Count), 32'd0);
    checkOutput("s5_empty", {31'b0, Empty}, 32'd1);
    checkOutput("s5_waddr", 32'(RegWriteAddr), 32'd0);
    tick(3);
    checkOutput("s5_nostale", 32'(writeLog.size()), 32'd0);
    checkOutput("s5_rf20", tbRf[20], 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
